// File: rtl/spi_host_pkg.sv
// Shared types and frame lengths for the SPI memory host.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP
    } state_t;

    localparam int CMD_LEN  = 8;
    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;
    localparam int BIT_W    = 6;

    // Latched copy of an accepted request.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/spi_host_clkgen.sv
// SCK divider: each SCK half-period lasts CLK_DIV clk cycles.
// tick marks the last cycle of a half-period; rise_stb/fall_stb mark the
// cycle whose closing clk edge raises/lowers SCK. sample_stb is the first
// cycle SCK is high. With sck_en low the divider still ticks but SCK stays
// low, which lets the top time the low-only tail phases with the same counter.
module spi_host_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sck_en,
    output logic sck,
    output logic tick,
    output logic rise_stb,
    output logic fall_stb,
    output logic sample_stb
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick       = run && (cnt == DIV_LAST);
    assign rise_stb   = tick && !sck;
    assign fall_stb   = tick && sck;
    assign sample_stb = run && sck && (cnt == '0);

    // Half-period counter and SCK level; idle forces both back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= !sck && sck_en;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_host_mem_master.sv
// SPI host issuing one 32-bit memory write or read per request.
// Frame: SETUP, CMD(8), ADDR(32), [DUMMY], DATA(32), HOLD, then csn-high GAP.
// A bit period is SCK high then low; phases advance on the rise_stb that
// closes a period, so every phase starts on a fresh divider count.
module spi_host_mem_master
    import spi_host_pkg::*;
#(
    parameter int          CLK_DIV      = 2,
    parameter int          DUMMY_CYCLES = 32,
    parameter logic [7:0]  CMD_WRITE    = 8'h02,
    parameter logic [7:0]  CMD_READ     = 8'h0B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_clk_o,
    output logic        spi_csn_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

    localparam int DUMMY_LAST = (DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1;

    state_t             state, next;
    req_t               req_q;
    logic [BIT_W-1:0]   bit_cnt, last_bit;
    logic [31:0]        sh_out, sh_in;
    logic               handshake, phase_done;
    logic               run, sck_en, tick, rise_stb, fall_stb, sample_stb;

    assign handshake  = req_valid && req_ready;
    assign run        = (state != IDLE);
    // The rise that would open a 33rd data period is suppressed so HOLD starts low.
    assign sck_en     = (state inside {SETUP, CMD, ADDR, DUMMY, DATA}) &&
                        !(state == DATA && bit_cnt == BIT_W'(DATA_LEN - 1));
    assign phase_done = rise_stb && (bit_cnt == last_bit);
    assign spi_sdo_o  = sh_out[31];

    spi_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .sck_en     (sck_en),
        .sck        (spi_clk_o),
        .tick       (tick),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .sample_stb (sample_stb)
    );

    // Index of the final bit period in the current phase.
    always_comb begin
        last_bit = BIT_W'(DATA_LEN - 1);
        case (state)
            CMD:     last_bit = BIT_W'(CMD_LEN - 1);
            ADDR:    last_bit = BIT_W'(ADDR_LEN - 1);
            DUMMY:   last_bit = BIT_W'(DUMMY_LAST);
            default: last_bit = BIT_W'(DATA_LEN - 1);
        endcase
    end

    // Next-state logic; writes and zero-dummy reads skip DUMMY.
    always_comb begin
        next = state;
        case (state)
            IDLE:  if (handshake)  next = SETUP;
            SETUP: if (rise_stb)   next = CMD;
            CMD:   if (phase_done) next = ADDR;
            ADDR:  if (phase_done) next = (req_q.we || DUMMY_CYCLES == 0) ? DATA : DUMMY;
            DUMMY: if (phase_done) next = DATA;
            DATA:  if (phase_done) next = HOLD;
            HOLD:  if (tick)       next = GAP;
            GAP:   if (tick)       next = IDLE;
            default:               next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Bit counter restarts on every phase change, counts closed periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             bit_cnt <= '0;
        else if (next != state) bit_cnt <= '0;
        else if (rise_stb)      bit_cnt <= bit_cnt + 1'b1;
    end

    // Registered handshake and chip-select, both derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            spi_csn_o <= 1'b1;
        end else begin
            req_ready <= (next == IDLE);
            spi_csn_o <= (next == IDLE) || (next == GAP);
        end
    end

    // Request latch; later req_* activity is ignored until the next handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         req_q <= '0;
        else if (handshake) req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
    end

    // MOSI shifter: loads the command at accept, the address after the last
    // command bit, write data (or zeros) after the last address bit. Shifting
    // in zeros keeps sdo low through DUMMY, read DATA and HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_out <= '0;
        end else if (handshake) begin
            sh_out <= {(req_we ? CMD_WRITE : CMD_READ), 24'h0};
        end else if (fall_stb) begin
            if (state == CMD && bit_cnt == BIT_W'(CMD_LEN - 1))
                sh_out <= req_q.addr;
            else if (state == ADDR && bit_cnt == BIT_W'(ADDR_LEN - 1))
                sh_out <= req_q.we ? req_q.wdata : 32'h0;
            else
                sh_out <= {sh_out[30:0], 1'b0};
        end
    end

    // MISO shifter: one sample per DATA period, in the first SCK-high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           sh_in <= '0;
        else if (state == DATA && sample_stb) sh_in <= {sh_in[30:0], spi_sdi_i};
    end

    // Completion pulse in the first GAP cycle; rdata holds until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == HOLD) && (next == GAP);
            if (state == HOLD && next == GAP)
                rsp_rdata <= req_q.we ? 32'h0 : sh_in;
        end
    end

endmodule
